// File: rtl/io_halt_sequencer.sv
// io_halt_sequencer: stalls/steps the PC around Input, Output and HALT,
// captures input words, drives the display and counts retired cycles.
module io_halt_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              halt,
  input  logic              input_flag,
  input  logic              output_flag,
  input  logic              in_confirm,
  input  logic [DATA_W-1:0] in_data,
  input  logic              resume,
  input  logic [DATA_W-1:0] out_value,
  output logic              pc_enable,
  output logic              reg_write_gate,
  output logic [DATA_W-1:0] in_value,
  output logic [DATA_W-1:0] out_display,
  output logic              out_strobe,
  output logic              halted,
  output logic              waiting_input,
  output logic [CNT_W-1:0]  retired_count
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_WAIT_IN = 2'd1,
    S_COMMIT  = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_conf_q;
  logic                r_res_q;
  logic [DATA_W-1:0]   r_in_value;
  logic [DATA_W-1:0]   r_disp;
  logic                r_strobe;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_conf_rise;
  logic                w_res_rise;
  logic                w_pc;
  logic                w_rwg;
  logic                w_capture;
  logic                w_show;

  assign w_conf_rise = in_confirm & ~r_conf_q;
  assign w_res_rise  = resume & ~r_res_q;

  // Next state and per-cycle PC / write-gate decisions.
  always_comb begin
    w_next    = r_state;
    w_pc      = 1'b0;
    w_rwg     = 1'b0;
    w_capture = 1'b0;
    w_show    = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (halt) begin
          w_next = S_HALTED;
        end else if (input_flag) begin
          w_next = S_WAIT_IN;
        end else begin
          w_pc   = 1'b1;
          w_rwg  = 1'b1;
          w_show = output_flag;
        end
      end
      S_WAIT_IN: begin
        if (w_conf_rise) begin
          w_capture = 1'b1;
          w_next    = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_pc   = 1'b1;
        w_rwg  = 1'b1;
        w_next = S_RUN;
      end
      S_HALTED: begin
        if (w_res_rise) begin
          w_pc   = 1'b1;
          w_next = S_RUN;
        end
      end
      default: w_next = S_RUN;
    endcase
  end

  // State register and button edge-detect history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_RUN;
      r_conf_q <= 1'b0;
      r_res_q  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_conf_q <= in_confirm;
      r_res_q  <= resume;
    end
  end

  // Input capture, display latch and its one-cycle strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_in_value <= '0;
      r_disp     <= '0;
      r_strobe   <= 1'b0;
    end else begin
      if (w_capture) r_in_value <= in_data;
      if (w_show) r_disp <= out_value;
      r_strobe <= w_show;
    end
  end

  // Saturating count of cycles in which the PC advanced.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_pc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign pc_enable      = w_pc & reset;
  assign reg_write_gate = w_rwg & reset;
  assign in_value       = r_in_value;
  assign out_display    = r_disp;
  assign out_strobe     = r_strobe;
  assign halted         = (r_state == S_HALTED);
  assign waiting_input  = (r_state == S_WAIT_IN);
  assign retired_count  = r_cnt;

endmodule

// File: tb/tb_io_halt_sequencer.sv
// tb_io_halt_sequencer: directed vectors, queue scoreboard for
// display strobes and input commits, inline per-cycle checks.
module tb_io_halt_sequencer;

  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          halt, input_flag, output_flag;
  logic          in_confirm, resume;
  logic [DW-1:0] in_data, out_value;
  logic          pc_enable, reg_write_gate;
  logic [DW-1:0] in_value, out_display;
  logic          out_strobe, halted, waiting_input;
  logic [15:0]   retired_count;

  logic          z_bit;
  logic [DW-1:0] z_word;
  logic          c_pc, c_rwg, c_strobe, c_halted, c_wait;
  logic [DW-1:0] c_inv, c_disp;
  logic [3:0]    c_cnt;

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;
  logic [DW-1:0] sq[$];
  logic [DW-1:0] cq[$];

  always #5 clock = ~clock;

  io_halt_sequencer #(.DATA_W(DW), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset),
    .halt(halt), .input_flag(input_flag), .output_flag(output_flag),
    .in_confirm(in_confirm), .in_data(in_data),
    .resume(resume), .out_value(out_value),
    .pc_enable(pc_enable), .reg_write_gate(reg_write_gate),
    .in_value(in_value), .out_display(out_display),
    .out_strobe(out_strobe), .halted(halted),
    .waiting_input(waiting_input), .retired_count(retired_count)
  );

  io_halt_sequencer #(.DATA_W(DW), .CNT_W(4)) u_cnt (
    .clock(clock), .reset(reset),
    .halt(z_bit), .input_flag(z_bit), .output_flag(z_bit),
    .in_confirm(z_bit), .in_data(z_word),
    .resume(z_bit), .out_value(z_word),
    .pc_enable(c_pc), .reg_write_gate(c_rwg),
    .in_value(c_inv), .out_display(c_disp),
    .out_strobe(c_strobe), .halted(c_halted),
    .waiting_input(c_wait), .retired_count(c_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle with the expected handshake outputs checked mid-cycle.
  task automatic cyc(input logic p, input logic r,
                     input logic h, input logic w);
    @(negedge clock);
    chk("pc_enable", {63'd0, pc_enable}, {63'd0, p});
    chk("reg_write_gate", {63'd0, reg_write_gate}, {63'd0, r});
    chk("halted", {63'd0, halted}, {63'd0, h});
    chk("waiting_input", {63'd0, waiting_input}, {63'd0, w});
    @(posedge clock);
    #1;
    if (p) exp_cnt++;
  endtask

  // Monitor: pops expectations when the DUT strobes or commits.
  initial begin
    logic pw;
    pw = 1'b0;
    forever begin
      @(negedge clock);
      if (out_strobe) begin
        if (sq.size() == 0) begin
          chk("unexpected_strobe", {63'd0, out_strobe}, 64'd0);
        end else begin
          chk("strobe_display", {32'd0, out_display}, {32'd0, sq.pop_front()});
        end
      end
      if (pc_enable && reg_write_gate && pw && !waiting_input) begin
        if (cq.size() == 0) begin
          chk("unexpected_commit", 64'd1, 64'd0);
        end else begin
          chk("commit_in_value", {32'd0, in_value}, {32'd0, cq.pop_front()});
        end
      end
      pw = waiting_input;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    halt = 1'b0; input_flag = 1'b0; output_flag = 1'b0;
    in_confirm = 1'b0; resume = 1'b0;
    in_data = '0; out_value = '0;
    z_bit = 1'b0; z_word = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pc_enable", {63'd0, pc_enable}, 64'd0);
    chk("rst_rwg", {63'd0, reg_write_gate}, 64'd0);
    chk("rst_in_value", {32'd0, in_value}, 64'd0);
    chk("rst_out_display", {32'd0, out_display}, 64'd0);
    chk("rst_count", {48'd0, retired_count}, 64'd0);
    chk("rst_flags", {61'd0, out_strobe, halted, waiting_input}, 64'd0);
    reset = 1'b1;

    // Input with a normal press after 5 stalled cycles.
    input_flag = 1'b1; in_data = 32'h0000_002A;
    cyc(0, 0, 0, 0);
    input_flag = 1'b0;
    repeat (5) cyc(0, 0, 0, 1);
    chk("in_value_before", {32'd0, in_value}, 64'd0);
    in_confirm = 1'b1; cq.push_back(32'h2A);
    cyc(0, 0, 0, 1);
    in_confirm = 1'b0;
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("in_value_2a", {32'd0, in_value}, 64'h2A);
    chk("count_after_input", {48'd0, retired_count}, 64'(exp_cnt));

    // Input with confirm already held on entry.
    in_confirm = 1'b1;
    cyc(1, 1, 0, 0);
    input_flag = 1'b1; in_data = 32'h0000_0055;
    cyc(0, 0, 0, 0);
    input_flag = 1'b0;
    repeat (3) cyc(0, 0, 0, 1);
    chk("held_no_capture", {32'd0, in_value}, 64'h2A);
    in_confirm = 1'b0;
    cyc(0, 0, 0, 1);
    in_confirm = 1'b1; cq.push_back(32'h55);
    cyc(0, 0, 0, 1);
    in_confirm = 1'b0;
    cyc(1, 1, 0, 0);
    chk("in_value_55", {32'd0, in_value}, 64'h55);

    // Two consecutive Output instructions.
    output_flag = 1'b1; out_value = 32'h11; sq.push_back(32'h11);
    cyc(1, 1, 0, 0);
    chk("display_11", {32'd0, out_display}, 64'h11);
    out_value = 32'h22; sq.push_back(32'h22);
    cyc(1, 1, 0, 0);
    chk("display_22", {32'd0, out_display}, 64'h22);
    output_flag = 1'b0;
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("strobe_cleared", {63'd0, out_strobe}, 64'd0);

    // Halt beats input/output; resume held on entry is ignored.
    resume = 1'b1;
    cyc(1, 1, 0, 0);
    halt = 1'b1; input_flag = 1'b1; output_flag = 1'b1;
    out_value = 32'h99;
    cyc(0, 0, 0, 0);
    halt = 1'b0; input_flag = 1'b0; output_flag = 1'b0;
    repeat (2) cyc(0, 0, 1, 0);
    resume = 1'b0;
    cyc(0, 0, 1, 0);
    resume = 1'b1;
    cyc(1, 0, 1, 0);
    resume = 1'b0;
    cyc(1, 1, 0, 0);
    chk("display_held", {32'd0, out_display}, 64'h22);
    chk("in_value_held", {32'd0, in_value}, 64'h55);
    chk("count_after_halt", {48'd0, retired_count}, 64'(exp_cnt));

    // Reset in WAIT_IN together with a confirm edge.
    input_flag = 1'b1; in_data = 32'h77;
    cyc(0, 0, 0, 0);
    input_flag = 1'b0;
    cyc(0, 0, 0, 1);
    in_confirm = 1'b1; reset = 1'b0;
    #1;
    chk("mid_rst_pc", {63'd0, pc_enable}, 64'd0);
    chk("mid_rst_wait", {63'd0, waiting_input}, 64'd0);
    chk("mid_rst_in_value", {32'd0, in_value}, 64'd0);
    chk("mid_rst_display", {32'd0, out_display}, 64'd0);
    chk("mid_rst_count", {48'd0, retired_count}, 64'd0);
    @(posedge clock);
    #1;
    chk("mid_rst_pc_hold", {63'd0, pc_enable}, 64'd0);
    in_confirm = 1'b0; reset = 1'b1; exp_cnt = 0;
    cyc(1, 1, 0, 0);
    chk("post_rst_count", {48'd0, retired_count}, 64'd1);
    chk("post_rst_in_value", {32'd0, in_value}, 64'd0);

    // Saturation of the 4-bit counter instance.
    repeat (9) cyc(1, 1, 0, 0);
    chk("cnt4_at_10", {60'd0, c_cnt}, 64'd10);
    repeat (10) cyc(1, 1, 0, 0);
    chk("cnt4_sat_20", {60'd0, c_cnt}, 64'd15);
    repeat (3) cyc(1, 1, 0, 0);
    chk("cnt4_sat_hold", {60'd0, c_cnt}, 64'd15);
    chk("count_16b", {48'd0, retired_count}, 64'(exp_cnt));

    repeat (2) @(posedge clock);
    #1;
    chk("strobe_queue_empty", 64'(sq.size()), 64'd0);
    chk("commit_queue_empty", 64'(cq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
